// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Byte handshake between a producer and the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    logic [7:0] DATA;
    logic       VALID;
    logic       READY;

    modport master (output DATA, output VALID, input  READY);
    modport slave  (input  DATA, input  VALID, output READY);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8-bit UART transmitter, optional parity, 1 or 2 stop bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic      CLK,
    input  logic      RESET,
    uart_tx_if.slave  bus,
    output logic      TXD,
    output logic      BUSY
);

    localparam int                 c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic               c_ODD       = (PARITY == 2);
    localparam logic               c_HAS_PAR   = (PARITY != 0);
    localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_tick;
    logic [2:0]         r_bit_idx;
    logic               r_stop_cnt;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic               r_txd;
    logic               w_line;
    logic               w_bit_done;
    logic               w_idle;

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_bit_done = (r_tick == c_TICK_LAST);
    assign bus.READY  = w_idle;
    assign BUSY       = ~w_idle;
    assign TXD        = r_txd;

    // Line level for the current state; registered into r_txd one cycle later
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            c_ST_START:  w_line = 1'b0;
            c_ST_DATA:   w_line = r_shift[0];
            c_ST_PARITY: w_line = r_parity;
            default:     w_line = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= c_ST_IDLE;
            r_tick     <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_txd <= w_line;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.VALID) begin
                        r_shift    <= bus.DATA;
                        r_parity   <= (^bus.DATA) ^ c_ODD;
                        r_tick     <= '0;
                        r_bit_idx  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_state    <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_bit_done) begin
                        r_tick  <= '0;
                        r_state <= c_ST_DATA;
                    end else begin
                        r_tick <= r_tick + c_CNT_W'(1);
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_done) begin
                        r_tick    <= '0;
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_HAS_PAR ? c_ST_PARITY : c_ST_STOP;
                        end
                    end else begin
                        r_tick <= r_tick + c_CNT_W'(1);
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_done) begin
                        r_tick  <= '0;
                        r_state <= c_ST_STOP;
                    end else begin
                        r_tick <= r_tick + c_CNT_W'(1);
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_done) begin
                        r_tick <= '0;
                        if (r_stop_cnt == c_LAST_STOP) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + c_CNT_W'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed bench for uart_tx: four instances (8N1, even, odd, 2 stop).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [3:0] valid;
    logic [7:0] data [4];
    wire  [3:0] txd;
    wire  [3:0] busy;
    wire  [3:0] ready;

    int n_checks;
    int n_err;
    int k;
    int lo_cnt;

    uart_tx_if bus0 ();
    uart_tx_if bus1 ();
    uart_tx_if bus2 ();
    uart_tx_if bus3 ();

    assign bus0.VALID = valid[0];
    assign bus1.VALID = valid[1];
    assign bus2.VALID = valid[2];
    assign bus3.VALID = valid[3];
    assign bus0.DATA  = data[0];
    assign bus1.DATA  = data[1];
    assign bus2.DATA  = data[2];
    assign bus3.DATA  = data[3];
    assign ready[0]   = bus0.READY;
    assign ready[1]   = bus1.READY;
    assign ready[2]   = bus2.READY;
    assign ready[3]   = bus3.READY;

    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_plain (
        .CLK(clk), .RESET(rst), .bus(bus0), .TXD(txd[0]), .BUSY(busy[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_even (
        .CLK(clk), .RESET(rst), .bus(bus1), .TXD(txd[1]), .BUSY(busy[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_odd (
        .CLK(clk), .RESET(rst), .bus(bus2), .TXD(txd[2]), .BUSY(busy[2]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .CLK(clk), .RESET(rst), .bus(bus3), .TXD(txd[3]), .BUSY(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int u);
        @(negedge clk);
        k++;
        if (!ready[u]) lo_cnt++;
    endtask

    // Each character of pat is one serial bit, held for 4 cycles
    task automatic expect_bits(input int u, input string pat, input string tag);
        for (int i = 0; i < pat.len(); i++) begin
            for (int c = 0; c < 4; c++) begin
                step(u);
                chk($sformatf("%s bit%0d c%0d", tag, i, c), {31'b0, txd[u]},
                    (pat[i] == "1") ? 32'd1 : 32'd0);
            end
        end
    endtask

    // Returns at the sample point just after the accepting edge (k = 0)
    task automatic accept(input int u, input logic [7:0] b, input string tag);
        @(negedge clk);
        valid[u] = 1'b1;
        data[u]  = b;
        @(negedge clk);
        valid[u] = 1'b0;
        k        = 0;
        lo_cnt   = ready[u] ? 0 : 1;
        chk({tag, " latency_txd"}, {31'b0, txd[u]}, 32'd1);
        chk({tag, " busy_on"},     {31'b0, busy[u]}, 32'd1);
    endtask

    task automatic frame(input int u, input logic [7:0] b, input string pat,
                         input int lo_exp, input string tag);
        accept(u, b, tag);
        expect_bits(u, pat, tag);
        chk({tag, " ready_low_cycles"}, lo_cnt, lo_exp);
        chk({tag, " ready_back"}, {31'b0, ready[u]}, 32'd1);
        chk({tag, " busy_off"},   {31'b0, busy[u]},  32'd0);
        step(u);
        chk({tag, " idle_txd"},   {31'b0, txd[u]},   32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        k        = 0;
        lo_cnt   = 0;
        rst      = 1'b1;
        valid    = 4'b0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int u = 0; u < 4; u++) begin
            chk($sformatf("reset txd u%0d", u),   {31'b0, txd[u]},   32'd1);
            chk($sformatf("reset ready u%0d", u), {31'b0, ready[u]}, 32'd1);
            chk($sformatf("reset busy u%0d", u),  {31'b0, busy[u]},  32'd0);
        end

        frame(0, 8'h55, "0101010101",  40, "single55");
        frame(1, 8'h07, "01110000011", 44, "even07");
        frame(2, 8'h07, "01110000001", 44, "odd07");
        frame(3, 8'hFF, "01111111111", 44, "stop2FF");

        // Back-to-back with VALID held; DATA changes right after the first accept
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        @(negedge clk);
        data[0]  = 8'h3C;
        k        = 0;
        lo_cnt   = 0;
        expect_bits(0, "0101001011", "b2b_A5");
        chk("b2b ready_gap", {31'b0, ready[0]}, 32'd1);
        step(0);
        valid[0] = 1'b0;
        chk("b2b gap_txd",    {31'b0, txd[0]},   32'd1);
        chk("b2b second_acc", {31'b0, ready[0]}, 32'd0);
        expect_bits(0, "0001111001", "b2b_3C");
        expect_bits(0, "11", "b2b_tail");
        chk("b2b start_spacing", k - 8, 81);

        // VALID pulsed while busy must be ignored
        accept(0, 8'h96, "ign");
        expect_bits(0, "001", "ign_pre");
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        expect_bits(0, "1", "ign_mid");
        valid[0] = 1'b0;
        expect_bits(0, "010011", "ign_post");
        expect_bits(0, "11", "ign_noextra");
        chk("ign ready_idle", {31'b0, ready[0]}, 32'd1);

        // Asynchronous reset during data bit 3 of 0x00
        accept(0, 8'h00, "rst");
        expect_bits(0, "0000", "rst_pre");
        step(0);
        chk("rst bit3_low", {31'b0, txd[0]}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst async_txd",   {31'b0, txd[0]},   32'd1);
        chk("rst async_ready", {31'b0, ready[0]}, 32'd1);
        chk("rst async_busy",  {31'b0, busy[0]},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame(0, 8'h81, "0100000011", 40, "post81");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
